// File: rtl/sha1_msg_feeder.sv
// sha1_msg_feeder: byte-stream SHA-1 padder and 16-word block loader for SHA1_core.
// Define SHA1_FEEDER_CONT_EN to add the `cont` port (continue from the core's current H state).
module sha1_msg_feeder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
`ifdef SHA1_FEEDER_CONT_EN
    input  logic        cont,
`endif
    output logic [31:0] core_data,
    output logic        core_start,
    output logic        core_restart,
    input  logic        core_ready,
    input  logic        core_valid,
    output logic        busy,
    output logic        msg_done
);
    localparam logic [2:0] ST_FILL = 3'd0;
    localparam logic [2:0] ST_PAD  = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;

    logic [2:0]        state;
    logic [15:0][31:0] blk_buf;
    logic [5:0]        pos;
    logic [60:0]       cnt;
    logic              final_q;
    logic              len_pending;
    logic              last_blk;
    logic              pad_started;
    logic              len_hi_done;
    logic              first_blk;
    logic              sending;
    logic [3:0]        k;

    logic              accept;
    logic              cont_first;
    logic              wr_en;
    logic [7:0]        wr_byte;
    logic [4:0]        lane_lsb;
    logic [63:0]       bit_len;

`ifdef SHA1_FEEDER_CONT_EN
    assign cont_first = cont;
`else
    assign cont_first = 1'b0;
`endif

    assign s_ready  = rst_n && (state == ST_FILL);
    assign accept   = s_valid && s_ready;
    assign bit_len  = {cnt, 3'b000};
    // byte 0 of each word sits in the most significant lane
    assign lane_lsb = {~pos[1:0], 3'b000};

    always_comb begin
        wr_en   = 1'b0;
        wr_byte = s_data;
        if (state == ST_FILL) begin
            wr_en = accept;
        end else if (state == ST_PAD) begin
            wr_en   = 1'b1;
            wr_byte = pad_started ? 8'h00 : 8'h80;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_FILL;
            blk_buf      <= '0;
            pos          <= '0;
            cnt          <= '0;
            final_q      <= 1'b0;
            len_pending  <= 1'b0;
            last_blk     <= 1'b0;
            pad_started  <= 1'b0;
            len_hi_done  <= 1'b0;
            first_blk    <= 1'b0;
            sending      <= 1'b0;
            k            <= '0;
            core_data    <= '0;
            core_start   <= 1'b0;
            core_restart <= 1'b0;
            busy         <= 1'b0;
            msg_done     <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            if (wr_en)
                blk_buf[pos[5:2]][lane_lsb +: 8] <= wr_byte;

            case (state)
                ST_FILL: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (!busy)
                            first_blk <= !cont_first;
                        // a continued message already has one 64-byte block behind it
                        cnt <= (busy ? cnt : (cont_first ? 61'd64 : 61'd0)) + 61'd1;
                        pos <= pos + 6'd1;
                        if (s_last)
                            final_q <= 1'b1;
                        if (pos == 6'd63)
                            state <= ST_SEND;
                        else if (s_last)
                            state <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    pad_started <= 1'b1;
                    pos         <= pos + 6'd1;
                    if (pos == 6'd55) begin
                        state <= ST_LEN;
                    end else if (pos == 6'd63) begin
                        len_pending <= 1'b1;
                        state       <= ST_SEND;
                    end
                end
                ST_LEN: begin
                    if (!len_hi_done) begin
                        blk_buf[14] <= bit_len[63:32];
                        len_hi_done <= 1'b1;
                    end else begin
                        blk_buf[15] <= bit_len[31:0];
                        len_hi_done <= 1'b0;
                        len_pending <= 1'b0;
                        last_blk    <= 1'b1;
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!sending) begin
                        if (core_ready) begin
                            sending      <= 1'b1;
                            k            <= 4'd1;
                            core_data    <= blk_buf[0];
                            core_restart <= first_blk;
                            core_start   <= !first_blk;
                        end
                    end else if (k != 4'd0) begin
                        core_data <= blk_buf[k];
                        k         <= k + 4'd1;
                    end else begin
                        sending      <= 1'b0;
                        core_data    <= '0;
                        core_start   <= 1'b0;
                        core_restart <= 1'b0;
                        first_blk    <= 1'b0;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (core_valid) begin
                        blk_buf <= '0;
                        pos     <= '0;
                        if (last_blk) begin
                            msg_done    <= 1'b1;
                            busy        <= 1'b0;
                            final_q     <= 1'b0;
                            last_blk    <= 1'b0;
                            pad_started <= 1'b0;
                            cnt         <= '0;
                            state       <= ST_FILL;
                        end else if (final_q || len_pending) begin
                            state <= ST_PAD;
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_sha1_msg_feeder.sv
// tb_sha1_msg_feeder: random/directed messages against a padded-block reference model,
// with a behavioural stand-in for SHA1_core on the word-load side.
`timescale 1ns/1ps
module tb_sha1_msg_feeder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        core_ready = 1'b0;
    logic        core_valid = 1'b0;
    logic        s_ready, core_start, core_restart, busy, msg_done;
    logic [31:0] core_data;
`ifdef SHA1_FEEDER_CONT_EN
    logic        cont = 1'b0;
`endif

    always #5 clk = ~clk;

    sha1_msg_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
`ifdef SHA1_FEEDER_CONT_EN
        .cont(cont),
`endif
        .core_data(core_data), .core_start(core_start), .core_restart(core_restart),
        .core_ready(core_ready), .core_valid(core_valid),
        .busy(busy), .msg_done(msg_done)
    );

    int n_asrt = 0;
    int n_fail = 0;

    logic [31:0] exp_w[$];
    bit          exp_rs[$];
    logic [31:0] got_w[$];
    bit          got_rs[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // core stand-in: capture strobe bursts, pulse valid some cycles later
    int          cap_n = 0;
    int          vcnt = -1;
    int          done_cnt = 0;
    longint      cyc = 0;
    longint      last_valid_cyc = 0;
    longint      done_cyc = 0;
    bit          force_stall = 1'b0;
    bit          rs_first = 1'b0;
    logic [31:0] cap_w[16];

    always @(negedge clk) begin
        cyc++;
        core_valid = 1'b0;
        if (!rst_n) begin
            cap_n = 0;
            vcnt  = -1;
        end else begin
            if (msg_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (core_start || core_restart) begin
                chk("strobe_exclusive", {63'd0, core_start & core_restart}, 64'd0);
                if (cap_n == 0) rs_first = core_restart;
                else chk("strobe_kind_stable", {63'd0, core_restart}, {63'd0, rs_first});
                if (cap_n < 16) cap_w[cap_n] = core_data;
                cap_n++;
            end else if (cap_n > 0) begin
                chk("strobe_len", cap_n, 16);
                for (int i = 0; i < 16; i++) got_w.push_back(cap_w[i]);
                got_rs.push_back(rs_first);
                cap_n = 0;
                vcnt  = $urandom_range(3, 25);
            end
            if (vcnt > 0) begin
                vcnt--;
            end else if (vcnt == 0) begin
                core_valid     = 1'b1;
                last_valid_cyc = cyc;
                vcnt           = -1;
            end
        end
        core_ready = rst_n && cap_n == 0 && vcnt < 0 && !force_stall && ($urandom_range(0, 3) != 0);
    end

    // reference: message + 0x80 + zeros to 56 mod 64 + 64-bit big-endian bit length
    task automatic build_exp(input byte unsigned m[$], input bit c);
        byte unsigned    p[$];
        longint unsigned bits;
        p = m;
        bits = (64'(m.size()) + (c ? 64'd64 : 64'd0)) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int w = 0; w < 16; w++)
                exp_w.push_back({p[64*b+4*w], p[64*b+4*w+1], p[64*b+4*w+2], p[64*b+4*w+3]});
            exp_rs.push_back(b == 0 && !c);
        end
    endtask

    task automatic clear_q();
        exp_w.delete(); exp_rs.delete(); got_w.delete(); got_rs.delete();
    endtask

    task automatic feed(input byte unsigned m[$], input int from, input int to, input bit last);
        for (int i = from; i < to; i++) begin
            int guard = 0;
            bit acc = 1'b0;
            while (!acc) begin
                @(negedge clk);
                s_valid = ($urandom_range(0, 4) != 0);
                s_data  = s_valid ? m[i] : 8'($urandom);
                s_last  = last && (i == to - 1);
                #1;
                acc = s_valid && s_ready;
                guard++;
                if (guard > 3000) begin
                    chk("feed_timeout", guard, 0);
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic finish_msg(input int tgt, input string tag);
        int guard = 0;
        chk({tag, "_busy_set"}, {63'd0, busy}, 1);
        while (done_cnt < tgt && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_done_once"}, done_cnt, tgt);
        chk({tag, "_done_after_last_valid"},
            {63'd0, (done_cyc >= last_valid_cyc) && (done_cyc - last_valid_cyc <= 1)}, 1);
        chk({tag, "_busy_clear"}, {63'd0, busy}, 0);
        chk({tag, "_blocks"}, got_rs.size(), exp_rs.size());
        for (int b = 0; b < exp_rs.size(); b++)
            chk($sformatf("%s_b%0d_restart", tag, b),
                {63'd0, (b < got_rs.size()) ? got_rs[b] : 1'bx}, {63'd0, exp_rs[b]});
        for (int i = 0; i < exp_w.size(); i++)
            chk($sformatf("%s_w%0d", tag, i),
                {32'd0, (i < got_w.size()) ? got_w[i] : 32'hxxxxxxxx}, {32'd0, exp_w[i]});
    endtask

    task automatic run_msg(input byte unsigned m[$], input bit c, input string tag);
        int tgt;
        clear_q();
        build_exp(m, c);
        tgt = done_cnt + 1;
`ifdef SHA1_FEEDER_CONT_EN
        cont = c;
`endif
        feed(m, 0, m.size(), 1'b1);
`ifdef SHA1_FEEDER_CONT_EN
        cont = 1'b0;
`endif
        finish_msg(tgt, tag);
    endtask

    initial begin
        byte unsigned m[$];
        int tgt;
        int guard;
        int lens[6] = '{55, 56, 63, 64, 120, 128};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", {63'd0, s_ready}, 0);
        chk("rst_core_data", {32'd0, core_data}, 0);
        chk("rst_core_start", {63'd0, core_start}, 0);
        chk("rst_core_restart", {63'd0, core_restart}, 0);
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_msg_done", {63'd0, msg_done}, 0);
        rst_n = 1'b1;
        #1;
        chk("s_ready_after_rst", {63'd0, s_ready}, 1);

        m.delete(); m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
        run_msg(m, 1'b0, "abc");
        chk("abc_word0_literal", {32'd0, got_w.size() > 0 ? got_w[0] : 32'hx}, 64'h61626380);
        chk("abc_word15_literal", {32'd0, got_w.size() > 15 ? got_w[15] : 32'hx}, 64'h18);

        foreach (lens[j]) begin
            m.delete();
            repeat (lens[j]) m.push_back(8'($urandom));
            run_msg(m, 1'b0, $sformatf("len%0d", lens[j]));
            if (lens[j] == 64) begin
                chk("len64_b1_word0", {32'd0, got_w.size() > 16 ? got_w[16] : 32'hx}, 64'h80000000);
                chk("len64_b1_word15", {32'd0, got_w.size() > 31 ? got_w[31] : 32'hx}, 64'h200);
            end
            if (lens[j] == 56)
                chk("len56_b0_word14", {32'd0, got_w.size() > 14 ? got_w[14] : 32'hx}, 64'h80000000);
        end

        for (int r = 0; r < 6; r++) begin
            m.delete();
            repeat ($urandom_range(1, 150)) m.push_back(8'($urandom));
            run_msg(m, 1'b0, $sformatf("rand%0d", r));
        end

        // core_ready held low on SEND entry: no strobe, no byte acceptance
        clear_q();
        m.delete();
        repeat (70) m.push_back(8'($urandom));
        build_exp(m, 1'b0);
        tgt = done_cnt + 1;
        force_stall = 1'b1;
        feed(m, 0, 64, 1'b0);
        repeat (10) begin
            @(negedge clk);
            #1;
            chk("stall_no_strobe", {62'd0, core_start, core_restart}, 0);
            chk("stall_s_ready", {63'd0, s_ready}, 0);
        end
        force_stall = 1'b0;
        feed(m, 64, 70, 1'b1);
        finish_msg(tgt, "stall");

        // reset in the middle of a block load
        clear_q();
        m.delete();
        repeat (64) m.push_back(8'($urandom));
        feed(m, 0, 64, 1'b0);
        guard = 0;
        while (cap_n < 7 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_word7", {63'd0, cap_n >= 7}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_core_start", {63'd0, core_start}, 0);
        chk("midrst_core_restart", {63'd0, core_restart}, 0);
        chk("midrst_s_ready", {63'd0, s_ready}, 0);
        chk("midrst_busy", {63'd0, busy}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m.delete(); m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
        run_msg(m, 1'b0, "abc_after_rst");

`ifdef SHA1_FEEDER_CONT_EN
        run_msg(m, 1'b1, "abc_cont");
        chk("cont_word15", {32'd0, got_w.size() > 15 ? got_w[15] : 32'hx}, 64'h218);
        chk("cont_uses_start", {63'd0, got_rs.size() > 0 ? got_rs[0] : 1'bx}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
